// File: rtl/conv1_kernel_fetch_ctrl_if.sv
// Weight stream from the conv1 kernel fetch controller to the conv1 MAC array.
// Each beat carries the weights at an even and an odd kernel offset.
interface conv1_kernel_fetch_ctrl_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data_a;
  logic [DATA_W-1:0] w_data_b;
  logic              w_b_valid;
  logic              w_last;

  modport master (
    output w_valid, w_data_a, w_data_b, w_b_valid, w_last,
    input  w_ready
  );

  modport slave (
    input  w_valid, w_data_a, w_data_b, w_b_valid, w_last,
    output w_ready
  );
endinterface

// File: rtl/conv1_kernel_fetch_ctrl.sv
// Streams one conv1 kernel out of a dual-port ROM (1-cycle read latency), two weights per beat.
// A 2-entry output FIFO plus in-flight read accounting absorbs MAC backpressure without re-reads.
module conv1_kernel_fetch_ctrl #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned KSIZE       = 25,
  parameter int unsigned NUM_KERNELS = 5,
  parameter int unsigned KIDX_W      = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [KIDX_W-1:0]         kernel_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_W-1:0]         rom_addr_a,
  output logic [ADDR_W-1:0]         rom_addr_b,
  input  logic [DATA_W-1:0]         rom_q_a,
  input  logic [DATA_W-1:0]         rom_q_b,
  conv1_kernel_fetch_ctrl_if.master w_bus
);

  localparam logic [ADDR_W-1:0] KSIZE_A = ADDR_W'(KSIZE);
  localparam logic [KIDX_W:0]   NUM_K   = (KIDX_W+1)'(NUM_KERNELS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] offset;
  logic [1:0]        fifo_count;
  logic              inflight;
  logic              inflight_bv;
  logic              inflight_last;
  logic [DATA_W-1:0] ent1_a;
  logic [DATA_W-1:0] ent1_b;
  logic              ent1_bv;
  logic              ent1_last;

  logic              pop;
  logic              push;
  logic [1:0]        occ;
  logic              issue;
  logic              pair_bv;
  logic              pair_last;
  logic              idx_ok;
  logic [ADDR_W-1:0] next_off;
  logic [ADDR_W-1:0] base_new;
  logic [DATA_W-1:0] push_b;

  // Port b address; on the odd-KSIZE final pair it repeats port a.
  function automatic logic [ADDR_W-1:0] b_addr(input logic [ADDR_W-1:0] b,
                                               input logic [ADDR_W-1:0] off);
    return ((off + ADDR_W'(1)) < KSIZE_A) ? (b + off + ADDR_W'(1)) : (b + off);
  endfunction

  // Issue a pair only if FIFO entries plus the read in flight, less this cycle's pop, leave room.
  always_comb begin
    pop       = w_bus.w_valid && w_bus.w_ready;
    push      = inflight;
    occ       = fifo_count + 2'(inflight);
    issue     = (state == S_FETCH) && ((occ < 2'd2) || ((occ == 2'd2) && pop));
    pair_bv   = (offset + ADDR_W'(1)) < KSIZE_A;
    pair_last = (offset + ADDR_W'(2)) >= KSIZE_A;
    next_off  = offset + ADDR_W'(2);
    idx_ok    = {1'b0, kernel_idx} < NUM_K;
    base_new  = ADDR_W'(kernel_idx) * KSIZE_A;
    push_b    = inflight_bv ? rom_q_b : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      base             <= '0;
      offset           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      rom_addr_a       <= '0;
      rom_addr_b       <= '0;
      inflight         <= 1'b0;
      inflight_bv      <= 1'b0;
      inflight_last    <= 1'b0;
      fifo_count       <= '0;
      ent1_a           <= '0;
      ent1_b           <= '0;
      ent1_bv          <= 1'b0;
      ent1_last        <= 1'b0;
      w_bus.w_valid    <= 1'b0;
      w_bus.w_data_a   <= '0;
      w_bus.w_data_b   <= '0;
      w_bus.w_b_valid  <= 1'b0;
      w_bus.w_last     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (idx_ok) begin
              base       <= base_new;
              offset     <= '0;
              rom_addr_a <= base_new;
              rom_addr_b <= b_addr(base_new, '0);
              busy       <= 1'b1;
              state      <= S_FETCH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (issue) begin
            if (pair_last) begin
              rom_addr_a <= '0;
              rom_addr_b <= '0;
              state      <= S_DRAIN;
            end else begin
              offset     <= next_off;
              rom_addr_a <= base + next_off;
              rom_addr_b <= b_addr(base, next_off);
            end
          end
        end
        S_DRAIN: begin
          if (pop && w_bus.w_last) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase

      inflight      <= issue;
      inflight_bv   <= pair_bv;
      inflight_last <= pair_last;

      // Head entry drives the bus directly; ent1 is the second slot.
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            w_bus.w_valid   <= 1'b1;
            w_bus.w_data_a  <= rom_q_a;
            w_bus.w_data_b  <= push_b;
            w_bus.w_b_valid <= inflight_bv;
            w_bus.w_last    <= inflight_last;
          end else begin
            ent1_a    <= rom_q_a;
            ent1_b    <= push_b;
            ent1_bv   <= inflight_bv;
            ent1_last <= inflight_last;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          if (fifo_count == 2'd2) begin
            w_bus.w_data_a  <= ent1_a;
            w_bus.w_data_b  <= ent1_b;
            w_bus.w_b_valid <= ent1_bv;
            w_bus.w_last    <= ent1_last;
          end else begin
            w_bus.w_valid   <= 1'b0;
            w_bus.w_data_a  <= '0;
            w_bus.w_data_b  <= '0;
            w_bus.w_b_valid <= 1'b0;
            w_bus.w_last    <= 1'b0;
          end
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            w_bus.w_data_a  <= rom_q_a;
            w_bus.w_data_b  <= push_b;
            w_bus.w_b_valid <= inflight_bv;
            w_bus.w_last    <= inflight_last;
          end else begin
            w_bus.w_data_a  <= ent1_a;
            w_bus.w_data_b  <= ent1_b;
            w_bus.w_b_valid <= ent1_bv;
            w_bus.w_last    <= ent1_last;
            ent1_a          <= rom_q_a;
            ent1_b          <= push_b;
            ent1_bv         <= inflight_bv;
            ent1_last       <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_kernel_fetch_ctrl.sv
// Scoreboard bench for conv1_kernel_fetch_ctrl: expected beats are queued at start and
// checked by an independent monitor against a ROM model with a 1-cycle registered read.
module tb_conv1_kernel_fetch_ctrl;
  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned KSIZE       = 25;
  localparam int unsigned NUM_KERNELS = 5;
  localparam int unsigned KIDX_W      = 3;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              bv;
    logic              last;
  } beat_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [KIDX_W-1:0] kernel_idx = '0;
  logic              busy, done, err;
  logic [ADDR_W-1:0] rom_addr_a, rom_addr_b;
  logic [DATA_W-1:0] rom_q_a, rom_q_b;
  logic [DATA_W-1:0] rom [0:127];

  conv1_kernel_fetch_ctrl_if #(.DATA_W(DATA_W)) w_bus ();

  conv1_kernel_fetch_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .KSIZE(KSIZE),
    .NUM_KERNELS(NUM_KERNELS), .KIDX_W(KIDX_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .kernel_idx(kernel_idx),
    .busy(busy), .done(done), .err(err),
    .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
    .rom_q_a(rom_q_a), .rom_q_b(rom_q_b),
    .w_bus(w_bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    rom_q_a <= rom[rom_addr_a];
    rom_q_b <= rom[rom_addr_b];
  end

  int    n_vec = 0;
  int    n_fail = 0;
  beat_t exp_q[$];
  int    hs_count = 0;
  logic  exp_done = 1'b0;
  logic  stall_prev = 1'b0;
  beat_t held;
  int    cur_base = 0;
  int    ready_mode = 0;
  int    cyc = 0;
  logic [3:0] ready_pat = 4'b1001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a == '0) || ((int'(a) >= cur_base) && (int'(a) < cur_base + int'(KSIZE)));
  endfunction

  // Reference: kernel k occupies words k*KSIZE .. k*KSIZE+KSIZE-1, paired (even, odd).
  task automatic expect_kernel(input int k);
    int base;
    beat_t e;
    base = k * int'(KSIZE);
    for (int o = 0; o < int'(KSIZE); o += 2) begin
      e.a    = rom[7'(base + o)];
      e.bv   = (o + 1) < int'(KSIZE);
      e.b    = e.bv ? rom[7'(base + o + 1)] : '0;
      e.last = (o + 2) >= int'(KSIZE);
      exp_q.push_back(e);
    end
  endtask

  // MAC-side ready: always, 1,0,0,1 pattern, or random.
  initial begin
    w_bus.w_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0:       w_bus.w_ready = 1'b1;
        1:       w_bus.w_ready = ready_pat[cyc % 4];
        default: w_bus.w_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability, done and addresses.
  always @(negedge clock) begin
    beat_t e;
    if (reset) begin
      stall_prev = 1'b0;
      exp_done   = 1'b0;
    end else begin
      if (done || exp_done) chk("done_pulse", 32'(done), 32'(exp_done));
      exp_done = 1'b0;
      if (stall_prev) begin
        chk("stall_valid", 32'(w_bus.w_valid), 32'd1);
        chk("stall_data", {w_bus.w_data_a, w_bus.w_data_b}, {held.a, held.b});
        chk("stall_flags", 32'({w_bus.w_b_valid, w_bus.w_last}), 32'({held.bv, held.last}));
      end
      if (w_bus.w_valid && w_bus.w_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 32'(hs_count), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data_a", 32'(w_bus.w_data_a), 32'(e.a));
          chk("beat_data_b", 32'(w_bus.w_data_b), 32'(e.b));
          chk("beat_b_valid", 32'(w_bus.w_b_valid), 32'(e.bv));
          chk("beat_last", 32'(w_bus.w_last), 32'(e.last));
          exp_done = e.last;
        end
      end
      stall_prev = w_bus.w_valid && !w_bus.w_ready;
      held = '{a: w_bus.w_data_a, b: w_bus.w_data_b, bv: w_bus.w_b_valid, last: w_bus.w_last};
      if (!busy) begin
        chk("idle_addr", 32'({rom_addr_a, rom_addr_b}), 32'd0);
      end else begin
        chk("addr_a_range", 32'(addr_ok(rom_addr_a)), 32'd1);
        chk("addr_b_range", 32'(addr_ok(rom_addr_b)), 32'd1);
      end
    end
  end

  task automatic start_kernel(input int k);
    hs_count = 0;
    cur_base = k * int'(KSIZE);
    expect_kernel(k);
    start = 1'b1;
    kernel_idx = KIDX_W'(k);
    @(posedge clock); #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_err", 32'(err), 32'd0);
  endtask

  task automatic wait_done(input bit inject);
    for (int i = 0; i < 400; i++) begin
      if (done) break;
      @(posedge clock); #1;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    if (inject) begin
      start = 1'b1;
      kernel_idx = '0;
    end
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("beats_outstanding", 32'(exp_q.size()), 32'd0);
    if (inject) begin
      repeat (3) begin
        @(posedge clock); #1;
        chk("ignored_start_busy", 32'(busy), 32'd0);
        chk("ignored_start_valid", 32'(w_bus.w_valid), 32'd0);
      end
    end
  endtask

  task automatic bad_idx(input int k);
    start = 1'b1;
    kernel_idx = KIDX_W'(k);
    @(posedge clock); #1;
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_valid", 32'(w_bus.w_valid), 32'd0);
    chk("err_addr", 32'({rom_addr_a, rom_addr_b}), 32'd0);
    @(posedge clock); #1;
    chk("err_clear", 32'(err), 32'd0);
    chk("err_busy2", 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 128; i++) rom[i] = 16'(i);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_w_flags", 32'({w_bus.w_valid, w_bus.w_b_valid, w_bus.w_last}), 32'd0);
    chk("rst_addr", 32'({rom_addr_a, rom_addr_b}), 32'd0);
    reset = 1'b0;

    // Kernel 0 with first-beat latency check.
    ready_mode = 0;
    start_kernel(0);
    chk("lat_e0", 32'(w_bus.w_valid), 32'd0);
    @(posedge clock); #1;
    chk("lat_e1", 32'(w_bus.w_valid), 32'd0);
    @(posedge clock); #1;
    chk("lat_e2", 32'(w_bus.w_valid), 32'd1);
    wait_done(1'b0);

    start_kernel(4);
    wait_done(1'b0);

    ready_mode = 1;
    start_kernel(2);
    wait_done(1'b0);
    ready_mode = 0;

    bad_idx(5);
    bad_idx(7);

    // Reset while the 4th beat is on the bus, then a clean restart.
    start_kernel(2);
    for (int i = 0; i < 200; i++) begin
      if (hs_count >= 3) break;
      @(posedge clock); #1;
    end
    chk("reach_beat4", 32'(hs_count >= 3), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    chk("midrst_valid", 32'(w_bus.w_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'({rom_addr_a, rom_addr_b}), 32'd0);
    reset = 1'b0;
    start_kernel(1);
    wait_done(1'b0);

    // start during FETCH and during DONE must be ignored.
    start_kernel(3);
    @(posedge clock); #1;
    start = 1'b1;
    kernel_idx = 3'd1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(1'b1);

    for (int i = 0; i < 128; i++) rom[i] = 16'($urandom);
    for (int n = 0; n < 10; n++) begin
      k = int'($urandom_range(0, 7));
      ready_mode = int'($urandom_range(0, 2));
      if (k < int'(NUM_KERNELS)) begin
        start_kernel(k);
        wait_done(1'($urandom_range(0, 1)));
      end else begin
        bad_idx(k);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
